// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter and select sequencer for a 4:1 single-bit mux.
// Grants one requester at a time, bounds each burst to SLOT_MAX cycles, and drives the mux select.
module mux4_rr_arbiter #(
    parameter int SLOT_MAX = 4,
    parameter int CW       = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] REQ,
    input  logic [3:0] I,
    output logic [1:0] S,
    output logic [3:0] GNT,
    output logic       BUSY,
    output logic       Y
);

    localparam logic [0:0]    ST_IDLE  = 1'b0;
    localparam logic [0:0]    ST_GRANT = 1'b1;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(SLOT_MAX);

    logic [0:0]    state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    s_q, s_d;
    logic [3:0]    gnt_q, gnt_d;
    logic          busy_q, busy_d;

    logic [1:0]    arb_ptr;
    logic          win_found;
    logic [1:0]    win_idx;

    // Returns {found, index}; descending scan so the smallest offset from ptr wins.
    function automatic logic [2:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic       found;
        logic [1:0] idx;
        logic [1:0] k;
        found = 1'b0;
        idx   = ptr;
        for (int j = 3; j >= 0; j--) begin
            k = ptr + 2'(j);
            if (req[k]) begin
                found = 1'b1;
                idx   = k;
            end
        end
        return {found, idx};
    endfunction

    // On a release the owner's successor is already the priority head in the same cycle.
    assign arb_ptr = (state_q == ST_GRANT) ? (s_q + 2'd1) : ptr_q;
    assign {win_found, win_idx} = rr_pick(REQ, arb_ptr);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    s_d     = win_idx;
                    gnt_d   = 4'b0001 << win_idx;
                    busy_d  = 1'b1;
                    cnt_d   = CNT_ONE;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (REQ[s_q] && (cnt_q < CNT_MAX)) begin
                    cnt_d = cnt_q + CNT_ONE;
                end else begin
                    ptr_d = s_q + 2'd1;
                    if (win_found) begin
                        s_d   = win_idx;
                        gnt_d = 4'b0001 << win_idx;
                        cnt_d = CNT_ONE;
                    end else begin
                        gnt_d   = 4'b0000;
                        busy_d  = 1'b0;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            s_q     <= 2'd0;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
        end
    end

    assign S    = s_q;
    assign GNT  = gnt_q;
    assign BUSY = busy_q;
    assign Y    = busy_q & I[s_q];

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: three instances (SLOT_MAX 4, 1, 2) share stimulus and are checked
// every cycle against an owner/hold-count model, plus directed sequences with literal expectations.
module tb_mux4_rr_arbiter;

    localparam int NI = 3;

    logic       CLK = 1'b0;
    logic       RST;
    logic [3:0] REQ;
    logic [3:0] I;

    logic [1:0] s_w    [NI];
    logic [3:0] gnt_w  [NI];
    logic       busy_w [NI];
    logic       y_w    [NI];
    logic [1:0] ptr_w  [NI];
    logic [2:0] cnt_w  [NI];

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    int m_owner [NI];
    int m_held  [NI];
    int m_ptr   [NI];
    int m_s     [NI];

    always #5 CLK = ~CLK;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            mux4_rr_arbiter #(
                .SLOT_MAX((gi == 0) ? 4 : ((gi == 1) ? 1 : 2)),
                .CW      (3)
            ) u_dut (
                .CLK (CLK),
                .RST (RST),
                .REQ (REQ),
                .I   (I),
                .S   (s_w[gi]),
                .GNT (gnt_w[gi]),
                .BUSY(busy_w[gi]),
                .Y   (y_w[gi])
            );
            assign ptr_w[gi] = u_dut.ptr_q;
            assign cnt_w[gi] = u_dut.cnt_q;
        end
    endgenerate

    function automatic int slot_of(input int n);
        return (n == 0) ? 4 : ((n == 1) ? 1 : 2);
    endfunction

    function automatic int pick(input logic [3:0] r, input int p);
        for (int j = 0; j < 4; j++) begin
            if (r[(p + j) % 4]) return (p + j) % 4;
        end
        return -1;
    endfunction

    task automatic check(input string name, input int n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, n, act, exp, $time);
        end
    endtask

    // Reference: who owns the mux, how long it has held, and where priority starts.
    task automatic model_edge();
        int w;
        for (int n = 0; n < NI; n++) begin
            if (RST) begin
                m_owner[n] = -1;
                m_held[n]  = 0;
                m_ptr[n]   = 0;
                m_s[n]     = 0;
            end else if (m_owner[n] < 0) begin
                w = pick(REQ, m_ptr[n]);
                if (w >= 0) begin
                    m_owner[n] = w;
                    m_s[n]     = w;
                    m_held[n]  = 1;
                end
            end else if (REQ[m_owner[n]] && m_held[n] < slot_of(n)) begin
                m_held[n]++;
            end else begin
                m_ptr[n] = (m_owner[n] + 1) % 4;
                w = pick(REQ, m_ptr[n]);
                if (w >= 0) begin
                    m_owner[n] = w;
                    m_s[n]     = w;
                    m_held[n]  = 1;
                end else begin
                    m_owner[n] = -1;
                    m_held[n]  = 0;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic [3:0] q, input logic [3:0] d);
        #1;
        RST = r;
        REQ = q;
        I   = d;
        @(posedge CLK);
        model_edge();
        @(negedge CLK);
    endtask

    always @(negedge CLK) begin : cmp
        int exp_busy;
        int exp_gnt;
        int exp_y;
        if (chk_en) begin
            for (int n = 0; n < NI; n++) begin
                exp_busy = (m_owner[n] >= 0) ? 1 : 0;
                exp_gnt  = exp_busy ? (1 << m_owner[n]) : 0;
                exp_y    = exp_busy ? int'(I[m_s[n]]) : 0;
                check("gnt", n, int'(gnt_w[n]), exp_gnt);
                check("s", n, int'(s_w[n]), m_s[n]);
                check("busy", n, int'(busy_w[n]), exp_busy);
                check("y", n, int'(y_w[n]), exp_y);
                check("ptr", n, int'(ptr_w[n]), m_ptr[n]);
                if (exp_busy != 0) check("cnt", n, int'(cnt_w[n]), m_held[n]);
            end
        end
    end

    initial begin
        logic [3:0] req_r;
        for (int n = 0; n < NI; n++) begin
            m_owner[n] = -1;
            m_held[n]  = 0;
            m_ptr[n]   = 0;
            m_s[n]     = 0;
        end
        RST = 1'b1;
        REQ = 4'b0000;
        I   = 4'b0000;
        chk_en = 1'b1;

        // Reset and idle, with all data inputs high
        step(1'b1, 4'b0000, 4'b0000);
        step(1'b1, 4'b0000, 4'b0000);
        for (int c = 0; c < 5; c++) begin
            step(1'b0, 4'b0000, 4'b1111);
            check("idle_gnt", 0, int'(gnt_w[0]), 0);
            check("idle_busy", 0, int'(busy_w[0]), 0);
            check("idle_s", 0, int'(s_w[0]), 0);
            check("idle_y", 0, int'(y_w[0]), 0);
        end

        // Single requester, two-cycle burst
        for (int c = 0; c < 2; c++) begin
            step(1'b0, 4'b0100, 4'b0100);
            check("short_gnt", 0, int'(gnt_w[0]), 4);
            check("short_s", 0, int'(s_w[0]), 2);
            check("short_y", 0, int'(y_w[0]), 1);
        end
        step(1'b0, 4'b0000, 4'b0100);
        check("short_busy", 0, int'(busy_w[0]), 0);
        check("short_ptr", 0, int'(ptr_w[0]), 3);

        // Slot limit of 4 between two continuous requesters
        for (int c = 0; c < 12; c++) begin
            step(1'b0, 4'b0011, 4'($urandom));
            check("slot_gnt", 0, int'(gnt_w[0]), (((c / 4) % 2) == 0) ? 1 : 2);
        end

        // Full rotation with SLOT_MAX = 1
        step(1'b1, 4'b0000, 4'b0000);
        for (int c = 0; c < 8; c++) begin
            step(1'b0, 4'b1111, 4'($urandom));
            check("rot_s", 1, int'(s_w[1]), c % 4);
            check("rot_gnt", 1, int'(gnt_w[1]), 1 << (c % 4));
        end

        // Lone requester re-grants itself with SLOT_MAX = 2
        step(1'b1, 4'b0000, 4'b0000);
        for (int c = 0; c < 6; c++) begin
            step(1'b0, 4'b1000, 4'($urandom));
            check("lone_gnt", 2, int'(gnt_w[2]), 8);
            check("lone_busy", 2, int'(busy_w[2]), 1);
            check("lone_cnt", 2, int'(cnt_w[2]), (c % 2) + 1);
        end

        // Reset in the middle of a grant
        step(1'b1, 4'b0000, 4'b0000);
        step(1'b0, 4'b0010, 4'b0000);
        check("mid_gnt0", 0, int'(gnt_w[0]), 2);
        step(1'b1, 4'b0010, 4'b0000);
        check("mid_gnt1", 0, int'(gnt_w[0]), 0);
        check("mid_busy1", 0, int'(busy_w[0]), 0);
        step(1'b0, 4'b1010, 4'b0000);
        check("mid_s2", 0, int'(s_w[0]), 1);
        check("mid_gnt2", 0, int'(gnt_w[0]), 2);

        // Randomised traffic with occasional resets
        req_r = 4'b0000;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) req_r = 4'($urandom);
            step(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0, req_r, 4'($urandom));
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
